apb_master_bridge: RTL
======================

Name: apb_master_bridge

Overview:
- APB requester (initiator) that drives the bus toward slave 1, complementing the existing APB memory responder.
- Accepts single read/write commands on a valid/ready command port.
- Runs the IDLE→SETUP→ACCESS sequence, waits on _PREADY with a bounded timeout, and returns read data and error status on a one-cycle response pulse.
- Sits between test/CPU-side logic and the APB slave; one transfer is outstanding at a time.

Parameters:
- ADDR_W, 32, width of _PADDR and cmd_addr.
- DATA_W, 32, width of _PWDATA, _PRDATA, cmd_wdata, rsp_rdata.
- TIMEOUT, 16, max ACCESS cycles with _PREADY low before abort; 0 disables the timeout.

Ports:
- _PCLK  input  1  bus clock; all logic on its rising edge.
- _PRESET  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  command accepted when cmd_valid && cmd_ready at a posedge.
- cmd_write  input  1  1 = write, 0 = read.
- cmd_addr  input  ADDR_W  transfer address.
- cmd_wdata  input  DATA_W  write data.
- rsp_valid  output  1  one-cycle pulse when a transfer completes.
- rsp_rdata  output  DATA_W  read data; valid with rsp_valid on reads.
- rsp_err  output  1  slave error or timeout; valid with rsp_valid.
- rsp_timeout  output  1  transfer was aborted by timeout; valid with rsp_valid.
- _PSEL1  output  1  slave select.
- _PENABLE  output  1  access phase.
- _PWRITE  output  1  direction.
- _PADDR  output  ADDR_W  address.
- _PWDATA  output  DATA_W  write data.
- _PRDATA  input  DATA_W  slave read data.
- _PREADY  input  1  slave ready.
- _PSLVERR  input  1  slave error.

Behaviour:
- Reset (sampled at posedge while _PRESET=1):
  - State goes to IDLE; wait counter clears.
  - All outputs go to 0, including _PADDR, _PWDATA, _PWRITE and all rsp_* outputs.
  - A transfer in flight is dropped with no response.
  - cmd_ready is 0 while _PRESET=1.
- States IDLE, SETUP, ACCESS; all bus outputs are registered.
- IDLE:
  - _PSEL1=0, _PENABLE=0, cmd_ready=1.
  - On accept, latch cmd_write/addr/wdata into _PWRITE/_PADDR/_PWDATA and go to SETUP.
- SETUP (exactly one cycle):
  - _PSEL1=1, _PENABLE=0, cmd_ready=0.
  - Next state is ACCESS.
- ACCESS:
  - _PSEL1=1, _PENABLE=1.
  - _PADDR, _PWRITE and _PWDATA stay stable from SETUP until completion.
- Completion is a posedge in ACCESS with _PREADY=1:
  - On the next cycle rsp_valid=1 for exactly one cycle.
  - rsp_err=_PSLVERR and rsp_timeout=0.
  - rsp_rdata=_PRDATA on reads; rsp_rdata holds its previous value on writes.
- Back-to-back transfers:
  - In ACCESS, cmd_ready = _PREADY (combinational).
  - If a command is accepted on the completing cycle, go directly to SETUP: _PSEL1 stays 1, _PENABLE drops to 0, and the new fields are latched.
  - Otherwise go to IDLE.
- Minimum transfer is 2 cycles (SETUP + one ACCESS). Zero-wait throughput is one transfer every 2 cycles.
- Timeout (TIMEOUT>0):
  - The counter clears on entry to ACCESS and increments each ACCESS cycle with _PREADY=0.
  - At a posedge where the counter equals TIMEOUT-1 and _PREADY=0, abort: go to IDLE (_PSEL1=0, _PENABLE=0).
  - The response pulse then carries rsp_err=1, rsp_timeout=1 and rsp_rdata=0.
  - cmd_ready stays 0 on the abort cycle, so a new command is first accepted in the following IDLE cycle.
- If _PREADY=1 on the same edge the counter reaches its limit, the transfer completes normally; _PREADY takes priority over timeout.
- _PSLVERR and _PRDATA are ignored except at completion.
- No protocol violations are generated: _PENABLE is never 1 without _PSEL1, and there is never an ACCESS without a preceding SETUP.

Test Plan:
- Write: cmd addr=0x04, wdata=0xA5A5_0001, slave _PREADY=1 immediately. Required: SETUP 1 cycle, ACCESS 1 cycle; _PADDR=0x04 and _PWDATA stable throughout; rsp_valid pulse with rsp_err=0.
- Read with 3 wait states: addr=0x04, slave returns _PRDATA=0xA5A5_0001 when _PREADY rises on the 4th ACCESS cycle. Required: rsp_rdata=0xA5A5_0001, rsp_err=0, _PSEL1 high for 5 cycles.
- Back-to-back: cmd_valid held with writes to 0x00, 0x01, 0x02 at zero wait. Required: _PSEL1 continuous for 6 cycles, _PENABLE toggling 0,1,0,1,0,1, and 3 response pulses.
- Slave error: read addr=0x1F with _PSLVERR=1 at completion. Required: rsp_err=1, rsp_timeout=0.
- Timeout: TIMEOUT=4, _PREADY held 0. Required: abort after 4 ACCESS cycles; rsp_err=1, rsp_timeout=1, rsp_rdata=0. A pending command is accepted 1 cycle later.
- Reset mid-transfer: assert _PRESET during ACCESS of a write. Required: next cycle all outputs 0, no rsp_valid, state IDLE; a subsequent read proceeds normally.

Source files
------------

// File: rtl/apb_master_bridge.sv
// APB requester: turns single valid/ready commands into IDLE->SETUP->ACCESS
// bus transfers toward slave 1, with a bounded wait and a one-cycle response pulse.
module apb_master_bridge #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              _PCLK,
    input  logic              _PRESET,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              _PSEL1,
    output logic              _PENABLE,
    output logic              _PWRITE,
    output logic [ADDR_W-1:0] _PADDR,
    output logic [DATA_W-1:0] _PWDATA,
    input  logic [DATA_W-1:0] _PRDATA,
    input  logic              _PREADY,
    input  logic              _PSLVERR
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   wait_q, wait_d;
    logic               psel_q, penable_q, pwrite_q;
    logic [ADDR_W-1:0]  paddr_q;
    logic [DATA_W-1:0]  pwdata_q;
    logic               rsp_valid_q, rsp_err_q, rsp_timeout_q;
    logic [DATA_W-1:0]  rsp_rdata_q;
    logic               at_limit, complete, abort_xfer, accept;

    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        cmd_ready  = 1'b0;
        at_limit   = (TIMEOUT > 0) && (wait_q == CNT_W'(TIMEOUT - 1));
        complete   = (state_q == ACCESS) && _PREADY;
        // A ready slave on the limit edge still completes normally.
        abort_xfer = (state_q == ACCESS) && !_PREADY && at_limit;

        case (state_q)
            IDLE:    cmd_ready = 1'b1;
            ACCESS:  cmd_ready = _PREADY;
            default: cmd_ready = 1'b0;
        endcase
        if (_PRESET) cmd_ready = 1'b0;
        accept = cmd_valid && cmd_ready;

        case (state_q)
            IDLE: begin
                if (accept) state_d = SETUP;
            end
            SETUP: begin
                state_d = ACCESS;
                wait_d  = '0;
            end
            ACCESS: begin
                if (complete)        state_d = accept ? SETUP : IDLE;
                else if (abort_xfer) state_d = IDLE;
                else if (TIMEOUT > 0) wait_d = wait_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge _PCLK) begin
        if (_PRESET) begin
            state_q       <= IDLE;
            wait_q        <= '0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            rsp_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            psel_q      <= (state_d != IDLE);
            penable_q   <= (state_d == ACCESS);
            rsp_valid_q <= complete || abort_xfer;
            if (accept) begin
                pwrite_q <= cmd_write;
                paddr_q  <= cmd_addr;
                pwdata_q <= cmd_wdata;
            end
            // pwrite_q still holds the finishing transfer's direction here.
            if (complete) begin
                rsp_err_q     <= _PSLVERR;
                rsp_timeout_q <= 1'b0;
                if (!pwrite_q) rsp_rdata_q <= _PRDATA;
            end else if (abort_xfer) begin
                rsp_err_q     <= 1'b1;
                rsp_timeout_q <= 1'b1;
                rsp_rdata_q   <= '0;
            end
        end
    end

    assign _PSEL1      = psel_q;
    assign _PENABLE    = penable_q;
    assign _PWRITE     = pwrite_q;
    assign _PADDR      = paddr_q;
    assign _PWDATA     = pwdata_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;
    assign rsp_rdata   = rsp_rdata_q;

endmodule
